mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Pipeline-to-memory-unit request/response bundle.
// The master (pipeline) issues requests. The slave (mem_access_unit) completes them.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-addressed data memory.
// It handles LW/LH/LHU/LB/LBU and SW/SH/SB.
// Sub-word stores use a read-modify-write of the containing word.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 65536
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus,
  output logic [31:0]        mem_read_address,
  output logic [31:0]        mem_write_address,
  output logic               mem_write_enable,
  output logic [31:0]        mem_data_in,
  input  logic [31:0]        mem_data_out
);

  localparam logic [2:0] OP_LW = 3'b000, OP_SW = 3'b001, OP_LB = 3'b010, OP_LBU = 3'b011,
                         OP_SB = 3'b100, OP_LH = 3'b101, OP_LHU = 3'b110, OP_SH = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW, S_WRITE, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, merge_q, merge_d, rdata_q, rdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;

  logic        req_err;
  logic [31:0] load_val, merge_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Misalignment and range check on the incoming request, evaluated at accept time.
  always_comb begin
    req_err = ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS);
    case (bus.req_op)
      OP_LW, OP_SW:         if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
      OP_LH, OP_LHU, OP_SH: if (bus.req_addr[0]) req_err = 1'b1;
      default: ;
    endcase
  end

  // Little-endian lane extraction and sign/zero extension of the read word.
  always_comb begin
    byte_sel = mem_data_out[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    case (op_q)
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'd0, byte_sel};
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'd0, half_sel};
      default: load_val = mem_data_out;
    endcase
  end

  // Per-byte-lane merge. The addressed lane(s) take the right-aligned store data.
  for (genvar n = 0; n < 4; n++) begin : g_lane
    logic hit;
    assign hit = ((op_q == OP_SB) && (addr_q[1:0] == 2'(n))) ||
                 ((op_q == OP_SH) && (addr_q[1] == 1'(n / 2)));
    assign merge_val[8*n +: 8] = !hit ? mem_data_out[8*n +: 8] :
                                 (op_q == OP_SB) ? wdata_q[7:0] : wdata_q[8*(n%2) +: 8];
  end

  // Next-state logic and latching of request/response fields.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        op_d    = bus.req_op;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        rd_d    = bus.req_rd;
        rdata_d = '0;
        err_d   = req_err;
        if (req_err)                      state_d = S_DONE;
        else if (bus.req_op == OP_SW)     state_d = S_WRITE;
        else if (bus.req_op == OP_SB ||
                 bus.req_op == OP_SH)     state_d = S_RMW;
        else                              state_d = S_LOAD;
      end
      S_LOAD:  begin rdata_d = load_val;  state_d = S_DONE;  end
      S_RMW:   begin merge_d = merge_val; state_d = S_WRITE; end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_rd    = rd_q;
  assign bus.resp_err   = err_q;

  assign mem_read_address  = {2'b00, addr_q[31:2]};
  assign mem_write_address = {2'b00, addr_q[31:2]};
  // A reset landing on the write cycle must not corrupt memory.
  assign mem_write_enable  = (state_q == S_WRITE) && !rst;
  assign mem_data_in       = (op_q == OP_SW) ? wdata_q : merge_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;
  localparam logic [2:0] LW = 3'b000, SW = 3'b001, LB = 3'b010, LBU = 3'b011,
                         SB = 3'b100, LH = 3'b101, LHU = 3'b110, SH = 3'b111;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] mem_read_address, mem_write_address, mem_data_in, mem_data_out;
  logic        mem_write_enable;
  logic [31:0] mem [0:65535];
  int vecs = 0;
  int errs = 0;
  int we_cnt = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_WORDS(65536)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_enable(mem_write_enable), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  assign mem_data_out = mem[mem_read_address[15:0]];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_write_address[15:0]] <= mem_data_in;
      we_cnt <= we_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  // Issue one op and wait (bounded) for its response. lat=0 means the response never came.
  task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, output int lat, output logic [31:0] rdata,
                       output logic err, output logic [4:0] rtag);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_rd = rd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; rdata = 'x; err = 1'bx; rtag = 'x;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = i; rdata = bus.resp_rdata; err = bus.resp_err; rtag = bus.resp_rd;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    vecs++; if (bus.req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    vecs++; if (bus.resp_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", bus.resp_valid); end
    vecs++; if ({bus.resp_err, bus.resp_rd, bus.resp_rdata} !== 38'd0) begin errs++;
      $display("FAIL reset_resp: got err=%b rd=%0d rdata=%h want all 0", bus.resp_err, bus.resp_rd, bus.resp_rdata); end
    vecs++; if (mem_write_enable !== 1'b0) begin errs++; $display("FAIL reset_we: got %b want 0", mem_write_enable); end
  endtask

  task automatic test_sw_lw;
    int lat; logic [31:0] rdata; logic err; logic [4:0] tag; int we0;
    we0 = we_cnt;
    do_op(SW, 32'h10, 32'hDEADBEEF, 5'd3, lat, rdata, err, tag);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL sw_latency: got %0d want 2", lat); end
    vecs++; if ({err, tag, rdata} !== {1'b0, 5'd3, 32'd0}) begin errs++;
      $display("FAIL sw_resp: got err=%b rd=%0d rdata=%h want 0/3/0", err, tag, rdata); end
    vecs++; if (mem[4] !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_mem: got %h want deadbeef", mem[4]); end
    vecs++; if (we_cnt - we0 !== 1) begin errs++; $display("FAIL sw_we_pulses: got %0d want 1", we_cnt - we0); end
    do_op(LW, 32'h10, 32'h0, 5'd7, lat, rdata, err, tag);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL lw_latency: got %0d want 2", lat); end
    vecs++; if ({err, tag, rdata} !== {1'b0, 5'd7, 32'hDEADBEEF}) begin errs++;
      $display("FAIL lw_resp: got err=%b rd=%0d rdata=%h want 0/7/deadbeef", err, tag, rdata); end
  endtask

  task automatic test_sub_stores;
    int lat; logic [31:0] rdata; logic err; logic [4:0] tag; int we0;
    we0 = we_cnt;
    do_op(SB, 32'h11, 32'h55, 5'd4, lat, rdata, err, tag);
    vecs++; if (lat !== 3) begin errs++; $display("FAIL sb_latency: got %0d want 3", lat); end
    vecs++; if (mem[4] !== 32'hDEAD55EF) begin errs++; $display("FAIL sb_mem: got %h want dead55ef", mem[4]); end
    vecs++; if (we_cnt - we0 !== 1) begin errs++; $display("FAIL sb_we_pulses: got %0d want 1", we_cnt - we0); end
    // Upper bits of wdata must be ignored for a byte store.
    do_op(SB, 32'h13, 32'hAAAAAA80, 5'd5, lat, rdata, err, tag);
    vecs++; if ({lat, err, rdata} !== {32'd3, 1'b0, 32'd0}) begin errs++;
      $display("FAIL sb_hi_resp: got lat=%0d err=%b rdata=%h want 3/0/0", lat, err, rdata); end
    vecs++; if (mem[4] !== 32'h80AD55EF) begin errs++; $display("FAIL sb_hi_mem: got %h want 80ad55ef", mem[4]); end
  endtask

  task automatic test_loads;
    logic [2:0]  ops [6] = '{LB, LBU, LH, LHU, LB, LBU};
    logic [31:0] ads [6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h11};
    logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AD, 32'h000055EF,
                             32'hFFFFFFEF, 32'h00000055};
    int lat; logic [31:0] rdata; logic err; logic [4:0] tag;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], ads[i], 32'h0, 5'(i + 10), lat, rdata, err, tag);
      vecs++; if ({lat, err, tag, rdata} !== {32'd2, 1'b0, 5'(i + 10), exp[i]}) begin errs++;
        $display("FAIL load_%0d: got lat=%0d err=%b rd=%0d rdata=%h want 2/0/%0d/%h",
                 i, lat, err, tag, rdata, i + 10, exp[i]); end
    end
  endtask

  task automatic test_sh;
    int lat; logic [31:0] rdata; logic err; logic [4:0] tag;
    do_op(SH, 32'h12, 32'hFFFF1234, 5'd6, lat, rdata, err, tag);
    vecs++; if ({lat, err} !== {32'd3, 1'b0}) begin errs++; $display("FAIL sh_resp: got lat=%0d err=%b want 3/0", lat, err); end
    vecs++; if (mem[4] !== 32'h123455EF) begin errs++; $display("FAIL sh_mem: got %h want 123455ef", mem[4]); end
    do_op(LH, 32'h12, 32'h0, 5'd8, lat, rdata, err, tag);
    vecs++; if (rdata !== 32'h00001234) begin errs++; $display("FAIL sh_readback: got %h want 00001234", rdata); end
  endtask

  task automatic test_errors;
    logic [2:0]  ops [3] = '{SW, LH, LW};
    logic [31:0] ads [3] = '{32'h12, 32'h01, 32'h40000};
    int lat; logic [31:0] rdata; logic err; logic [4:0] tag; int we0;
    we0 = we_cnt;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], ads[i], 32'hFFFFFFFF, 5'(20 + i), lat, rdata, err, tag);
      vecs++; if ({lat, err, tag, rdata} !== {32'd1, 1'b1, 5'(20 + i), 32'd0}) begin errs++;
        $display("FAIL err_%0d: got lat=%0d err=%b rd=%0d rdata=%h want 1/1/%0d/0",
                 i, lat, err, tag, rdata, 20 + i); end
    end
    vecs++; if (we_cnt !== we0) begin errs++; $display("FAIL err_no_write: got %0d pulses want 0", we_cnt - we0); end
    vecs++; if (mem[4] !== 32'h123455EF) begin errs++; $display("FAIL err_mem4: got %h want 123455ef", mem[4]); end
    // The last in-range word is legal.
    do_op(SW, 32'h3FFFC, 32'hCAFEF00D, 5'd1, lat, rdata, err, tag);
    vecs++; if ({lat, err} !== {32'd2, 1'b0}) begin errs++; $display("FAIL top_sw: got lat=%0d err=%b want 2/0", lat, err); end
    do_op(LW, 32'h3FFFC, 32'h0, 5'd2, lat, rdata, err, tag);
    vecs++; if ({err, rdata} !== {1'b0, 32'hCAFEF00D}) begin errs++;
      $display("FAIL top_lw: got err=%b rdata=%h want 0/cafef00d", err, rdata); end
  endtask

  task automatic test_back_to_back;
    logic rv_exp [5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic rdy_exp [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = LW; bus.req_addr = 32'h10; bus.req_rd = 5'd1;
    @(posedge clk); #1;
    // Changed while busy: must not disturb the op in flight, and is taken on the next accept.
    bus.req_addr = 32'h3FFFC; bus.req_rd = 5'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++; if ({bus.resp_valid, bus.req_ready} !== {rv_exp[i], rdy_exp[i]}) begin errs++;
        $display("FAIL b2b_cycle%0d: got valid=%b ready=%b want %b/%b",
                 i, bus.resp_valid, bus.req_ready, rv_exp[i], rdy_exp[i]); end
      if (i == 1) begin
        vecs++; if ({bus.resp_rd, bus.resp_rdata} !== {5'd1, 32'h123455EF}) begin errs++;
          $display("FAIL b2b_first: got rd=%0d rdata=%h want 1/123455ef", bus.resp_rd, bus.resp_rdata); end
      end
      if (i == 4) begin
        vecs++; if ({bus.resp_rd, bus.resp_rdata} !== {5'd2, 32'hCAFEF00D}) begin errs++;
          $display("FAIL b2b_second: got rd=%0d rdata=%h want 2/cafef00d", bus.resp_rd, bus.resp_rdata); end
        bus.req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_in_write;
    int lat; logic [31:0] rdata; logic err; logic [4:0] tag; int we0; int seen;
    do_op(SW, 32'h14, 32'h11111111, 5'd3, lat, rdata, err, tag);
    vecs++; if (mem[5] !== 32'h11111111) begin errs++; $display("FAIL rw_setup: got %h want 11111111", mem[5]); end
    we0 = we_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = SW; bus.req_addr = 32'h14;
    bus.req_wdata = 32'h22222222; bus.req_rd = 5'd9;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    vecs++; if (mem_write_enable !== 1'b0) begin errs++; $display("FAIL rw_we_suppressed: got %b want 0", mem_write_enable); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        vecs++; if (bus.req_ready !== 1'b1) begin errs++; $display("FAIL rw_ready: got %b want 1", bus.req_ready); end
        vecs++; if ({bus.resp_err, bus.resp_rd, bus.resp_rdata} !== 38'd0) begin errs++;
          $display("FAIL rw_resp_cleared: got err=%b rd=%0d rdata=%h want 0", bus.resp_err, bus.resp_rd, bus.resp_rdata); end
      end
      if (bus.resp_valid) seen++;
    end
    vecs++; if (seen !== 0) begin errs++; $display("FAIL rw_no_resp: got %0d pulses want 0", seen); end
    vecs++; if (mem[5] !== 32'h11111111) begin errs++; $display("FAIL rw_mem: got %h want 11111111", mem[5]); end
    vecs++; if (we_cnt !== we0) begin errs++; $display("FAIL rw_we_count: got %0d pulses want 0", we_cnt - we0); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_rd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_sw_lw;
    test_sub_stores;
    test_loads;
    test_sh;
    test_errors;
    test_back_to_back;
    test_reset_in_write;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
